// File: rtl/synth_pkg.sv
// Shared widths, constants and state encoding
// for the sample-rate buffer slice.
package synth_pkg;

  localparam int SAMPLE_W = 12;
  localparam logic [SAMPLE_W-1:0] SILENCE = 12'h800;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/sample_fifo.sv
// Registered-pointer synchronous FIFO holding
// 12-bit samples; clear has priority over push/pop.
module sample_fifo
  import synth_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                push_i,
  input  logic [SAMPLE_W-1:0] wdata_i,
  input  logic                pop_i,
  output logic [SAMPLE_W-1:0] rdata_o,
  output logic [AW:0]         count_o,
  output logic                full_o,
  output logic                empty_o
);

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_q;
  logic [AW-1:0]       rd_q;
  logic [AW:0]         cnt_q;
  logic                do_push;
  logic                do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/sample_rate_buffer.sv
// Primes a small FIFO, then releases one sample
// per pacer tick toward the PWM domain.
module sample_rate_buffer
  import synth_pkg::*;
#(
  parameter int CPU_CLOCK_FREQ = 125_000_000,
  parameter int SAMPLE_RATE    = 30_000,
  parameter int DEPTH          = 8,
  parameter int PRIME_LEVEL    = 4,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [SAMPLE_W-1:0] in_sample,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [SAMPLE_W-1:0] out_sample,
  output logic                out_valid,
  output logic [LW-1:0]       fill_level,
  output logic [15:0]         underflow_count
);

  localparam int CPS = CPU_CLOCK_FREQ / SAMPLE_RATE;
  localparam int CW  = (CPS > 1) ? $clog2(CPS) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CPS - 1);

  logic                alive_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic                tick;
  state_e              state_q;
  state_e              state_d;
  logic [SAMPLE_W-1:0] out_q;
  logic [SAMPLE_W-1:0] out_d;
  logic [15:0]         unf_q;
  logic [15:0]         unf_d;
  logic                vld_q;
  logic [SAMPLE_W-1:0] head;
  logic                pop;
  logic                push;
  logic                full;
  logic                empty;
  logic [LW-1:0]       fill;

  assign tick  = (cnt_q == CMAX);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  // Ready only from registered occupancy: no pop bypass.
  assign in_ready = alive_q && !full;
  assign push     = in_valid && in_ready && !flush;

  sample_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .clr_i  (flush),
    .push_i (push),
    .wdata_i(in_sample),
    .pop_i  (pop && !flush),
    .rdata_o(head),
    .count_o(fill),
    .full_o (full),
    .empty_o(empty)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    unf_d   = unf_q;
    pop     = 1'b0;
    if (tick) begin
      unique case (state_q)
        PRIME: begin
          out_d = SILENCE;
          if (fill >= LW'(PRIME_LEVEL)) begin
            state_d = RUN;
            pop     = 1'b1;
            out_d   = head;
          end
        end
        RUN: begin
          if (!empty) begin
            pop   = 1'b1;
            out_d = head;
          end else if (unf_q != 16'hFFFF) begin
            unf_d = unf_q + 16'd1;
          end
        end
        default: state_d = PRIME;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= PRIME;
      out_q   <= SILENCE;
      unf_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (flush) begin
        cnt_q   <= '0;
        state_q <= PRIME;
        out_q   <= SILENCE;
        unf_q   <= '0;
        vld_q   <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        state_q <= state_d;
        out_q   <= out_d;
        unf_q   <= unf_d;
        vld_q   <= tick;
      end
    end
  end

  assign out_sample      = out_q;
  assign out_valid       = vld_q;
  assign fill_level      = fill;
  assign underflow_count = unf_q;

endmodule

// File: tb/tb_sample_rate_buffer.sv
// Randomized and directed checks of sample_rate_buffer
// against a queue-based reference model.
module tb_sample_rate_buffer;

  localparam int CPS   = 10;
  localparam int DEPTH = 8;
  localparam int PL    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_sample = '0;
  logic        in_ready;
  logic        out_valid;
  logic [11:0] out_sample;
  logic [3:0]  fill_level;
  logic [15:0] underflow_count;

  logic        s_rst = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_ov;
  logic [11:0] s_out;
  logic [3:0]  s_fill;
  logic [15:0] s_unf;

  int errs = 0;
  int n_chk = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  sample_rate_buffer #(
    .CPU_CLOCK_FREQ(100),
    .SAMPLE_RATE   (10),
    .DEPTH         (DEPTH),
    .PRIME_LEVEL   (PL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_sample      (in_sample),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_sample     (out_sample),
    .out_valid      (out_valid),
    .fill_level     (fill_level),
    .underflow_count(underflow_count)
  );

  // One tick per cycle so saturation is reachable quickly.
  sample_rate_buffer #(
    .CPU_CLOCK_FREQ(10),
    .SAMPLE_RATE   (10),
    .DEPTH         (DEPTH),
    .PRIME_LEVEL   (PL)
  ) sat (
    .clk            (clk),
    .rst            (s_rst),
    .flush          (1'b0),
    .in_sample      (12'h123),
    .in_valid       (s_valid),
    .in_ready       (s_ready),
    .out_sample     (s_out),
    .out_valid      (s_ov),
    .fill_level     (s_fill),
    .underflow_count(s_unf)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Reference model
  int          q[$];
  bit          m_run = 0;
  bit          m_alive = 0;
  bit          m_vld = 0;
  int          m_t = 0;
  int          m_unf = 0;
  logic [11:0] m_out = 12'h800;

  always @(posedge clk or negedge rst) begin : model
    bit tick;
    bit acc;
    if (!rst) begin
      q.delete();
      m_run = 0; m_alive = 0; m_vld = 0;
      m_t = 0; m_unf = 0; m_out = 12'h800;
    end else if (flush) begin
      q.delete();
      m_run = 0; m_vld = 0; m_t = 0;
      m_unf = 0; m_out = 12'h800;
      m_alive = 1;
    end else begin
      tick = ((m_t % CPS) == CPS - 1);
      acc = in_valid && m_alive && (q.size() < DEPTH);
      m_vld = tick;
      if (tick) begin
        if (!m_run) begin
          m_out = 12'h800;
          if (q.size() >= PL) begin
            m_run = 1;
            m_out = 12'(q.pop_front());
          end
        end else if (q.size() > 0) begin
          m_out = 12'(q.pop_front());
        end else if (m_unf < 65535) begin
          m_unf++;
        end
      end
      if (acc) q.push_back(int'(in_sample));
      m_t++;
      m_alive = 1;
    end
  end

  always @(negedge clk) begin
    check("out_valid", 32'(out_valid), 32'(m_vld));
    check("out_sample", 32'(out_sample), 32'(m_out));
    check("fill_level", 32'(fill_level), 32'(q.size()));
    check("in_ready", 32'(in_ready),
          32'(m_alive && q.size() < DEPTH));
    check("underflow", 32'(underflow_count), 32'(m_unf));
  end

  logic [11:0] vq[$];
  int          vt[$];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (out_valid) begin
      vq.push_back(out_sample);
      vt.push_back(cyc);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_sample = v;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    step();
    in_valid = 1'b0;
    if (n >= 200) check("push_timeout", 1, 0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_pulses(input int k);
    int n;
    n = 0;
    while (vq.size() < k && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("pulse_timeout", 1, 0);
  endtask

  task automatic main_seq();
    int acc;
    int n;
    int n9;
    bit rdy;
    // Underfilled: stays silent in PRIME
    push(12'h011); push(12'h022); push(12'h033);
    vq.delete();
    repeat (40) step();
    check("prime_pulses", 32'(vq.size()), 4);
    foreach (vq[i]) check("prime_silence", 32'(vq[i]), 32'h800);
    check("prime_unf", 32'(underflow_count), 0);

    // Prime and play back in order
    do_flush();
    vq.delete(); vt.delete();
    push(12'h100); push(12'h200);
    push(12'h300); push(12'h400);
    wait_pulses(4);
    if (vq.size() >= 4) begin
      check("play0", 32'(vq[0]), 32'h100);
      check("play1", 32'(vq[1]), 32'h200);
      check("play2", 32'(vq[2]), 32'h300);
      check("play3", 32'(vq[3]), 32'h400);
      check("spacing", 32'(vt[3] - vt[0]), 30);
    end

    // Starvation holds last sample
    wait_pulses(7);
    check("drain_hold", 32'(out_sample), 32'h400);
    check("drain_unf", 32'(underflow_count), 3);

    // Full FIFO backpressure
    do_flush();
    in_valid = 1'b1;
    acc = 0; n = 0; n9 = 0;
    while (acc < 9 && n < 100) begin
      in_sample = 12'h500 + 12'(acc);
      rdy = in_ready;
      step();
      n++;
      if (rdy) begin
        acc++;
        if (acc == 8) begin
          check("full_fill", 32'(fill_level), 8);
          check("full_ready", 32'(in_ready), 0);
        end
        if (acc == 9) n9 = n;
      end
    end
    in_valid = 1'b0;
    check("ninth_acc", 32'(acc), 9);
    check("ninth_cycle", 32'(n9), 11);

    // Flush on a tick cycle with in_valid high
    n = 0;
    while ((m_t % CPS) != CPS - 1 && n < 50) begin
      step();
      n++;
    end
    flush = 1'b1;
    in_valid = 1'b1;
    in_sample = 12'hABC;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_fill", 32'(fill_level), 0);
    check("fl_out", 32'(out_sample), 32'h800);
    check("fl_unf", 32'(underflow_count), 0);
    check("fl_vld", 32'(out_valid), 0);

    // Async reset mid-RUN
    do_flush();
    for (int i = 0; i < 6; i++) push(12'h600 + 12'(i));
    vq.delete();
    wait_pulses(1);
    check("run_fill5", 32'(fill_level), 5);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("ar_out", 32'(out_sample), 32'h800);
    check("ar_vld", 32'(out_valid), 0);
    check("ar_rdy", 32'(in_ready), 0);
    check("ar_fill", 32'(fill_level), 0);
    check("ar_unf", 32'(underflow_count), 0);
    step(); step();
    rst = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!out_valid && n < 50);
    check("rel_latency", 32'(n), 10);
    check("rel_out", 32'(out_sample), 32'h800);

    // Randomized traffic
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 500; c++) begin
        in_valid = ((ph % 2) == 0) ? ($urandom_range(9) != 0)
                                   : ($urandom_range(9) == 0);
        in_sample = 12'($urandom);
        flush = ($urandom_range(299) == 0);
        step();
      end
    end
    in_valid = 1'b0;
    flush = 1'b0;
    step();
  endtask

  task automatic sat_seq();
    step();
    s_valid = 1'b1;
    repeat (6) step();
    s_valid = 1'b0;
    repeat (40000) step();
    check("sat_mid", 32'(s_unf > 16'd0 && s_unf < 16'hFFFF), 1);
    repeat (30000) step();
    check("sat_max", 32'(s_unf), 32'hFFFF);
  endtask

  initial begin
    repeat (3) step();
    check("rst_rdy", 32'(in_ready), 0);
    check("rst_out", 32'(out_sample), 32'h800);
    check("rst_vld", 32'(out_valid), 0);
    check("rst_fill", 32'(fill_level), 0);
    check("rst_unf", 32'(underflow_count), 0);
    rst = 1'b1;
    s_rst = 1'b1;
    step();
    fork
      main_seq();
      sat_seq();
    join
    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end

endmodule
